// File: rtl/csr_trap_seq.sv
// Sequencer between decode/execute and the CSR file. It turns one system
// instruction at a time into single-port CSR writes, a completion pulse and PC redirects.
module csr_trap_seq #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_pc,
  input  logic [11:0] in_csr,
  input  logic [31:0] in_src,
  output logic [11:0] csr_rd_reg,
  input  logic [31:0] csr_rd_bus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        csr_wr_en,
  output logic        csr_wr_set,
  output logic [11:0] csr_wr_reg,
  output logic [31:0] csr_wr_bus,
  output logic        done_valid,
  output logic [31:0] done_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [2:0]  OP_CSRRW   = 3'b001;
  localparam logic [2:0]  OP_CSRRS   = 3'b010;
  localparam logic [2:0]  OP_ECALL   = 3'b011;
  localparam logic [2:0]  OP_MRET    = 3'b100;
  localparam logic [11:0] ADDR_MEPC  = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;

  typedef enum logic [2:0] {
    IDLE, CSR_WR, EPC, CAUSE, JUMP, RET, NOPD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_op;
  logic [31:0] r_pc;
  logic [11:0] r_csr;
  logic [31:0] r_src;
  logic [31:0] r_old;
  logic        w_accept;

  assign in_ready   = (r_state == IDLE) && !rst;
  assign busy       = (r_state != IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign csr_rd_reg = (r_state == IDLE) ? in_csr : r_csr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_pc    <= '0;
      r_csr   <= '0;
      r_src   <= '0;
      r_old   <= '0;
    end else begin
      r_state <= w_next;
      // The old value is captured before this instruction's own write commits
      if (w_accept) begin
        r_op  <= in_op;
        r_pc  <= in_pc;
        r_csr <= in_csr;
        r_src <= in_src;
        r_old <= csr_rd_bus;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    csr_wr_en      = 1'b0;
    csr_wr_set     = 1'b0;
    csr_wr_reg     = '0;
    csr_wr_bus     = '0;
    done_valid     = 1'b0;
    done_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    // Outputs stay quiet during reset so an aborted sequence issues nothing more
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (in_op)
              OP_CSRRW, OP_CSRRS: w_next = CSR_WR;
              OP_ECALL:           w_next = EPC;
              OP_MRET:            w_next = RET;
              default:            w_next = NOPD;
            endcase
          end
        end
        CSR_WR: begin
          // CSRRS with a zero mask must not touch the CSR
          if (!((r_op == OP_CSRRS) && (r_src == '0))) begin
            csr_wr_en  = 1'b1;
            csr_wr_set = (r_op == OP_CSRRS);
            csr_wr_reg = r_csr;
            csr_wr_bus = r_src;
          end
          done_valid = 1'b1;
          done_rdata = r_old;
          w_next     = IDLE;
        end
        EPC: begin
          csr_wr_en  = 1'b1;
          csr_wr_reg = ADDR_MEPC;
          csr_wr_bus = r_pc;
          w_next     = CAUSE;
        end
        CAUSE: begin
          csr_wr_en  = 1'b1;
          csr_wr_reg = ADDR_MCAUSE;
          csr_wr_bus = ECALL_CAUSE;
          w_next     = JUMP;
        end
        JUMP: begin
          redirect_valid = 1'b1;
          redirect_pc    = mtvec & ~32'h3;
          done_valid     = 1'b1;
          w_next         = IDLE;
        end
        RET: begin
          redirect_valid = 1'b1;
          redirect_pc    = mepc;
          done_valid     = 1'b1;
          w_next         = IDLE;
        end
        NOPD: begin
          done_valid = 1'b1;
          w_next     = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: a small CSR file as environment, a per-instruction
// expectation model, a directed vector table, multi-cycle corner sequences and random traffic.
module tb_csr_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        fileRst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_pc;
  logic [11:0] in_csr;
  logic [31:0] in_src;
  logic [11:0] csr_rd_reg;
  logic [31:0] csr_rd_bus;
  logic        csr_wr_en;
  logic        csr_wr_set;
  logic [11:0] csr_wr_reg;
  logic [31:0] csr_wr_bus;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  logic [31:0] fMstatus, fMtvec, fMepc, fMcause;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  csr_trap_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_csr(in_csr), .in_src(in_src),
    .csr_rd_reg(csr_rd_reg), .csr_rd_bus(csr_rd_bus),
    .mtvec(fMtvec), .mepc(fMepc),
    .csr_wr_en(csr_wr_en), .csr_wr_set(csr_wr_set),
    .csr_wr_reg(csr_wr_reg), .csr_wr_bus(csr_wr_bus),
    .done_valid(done_valid), .done_rdata(done_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy)
  );

  // Environment CSR file: four known registers, unknown addresses read 0
  always_comb begin
    csr_rd_bus = '0;
    case (csr_rd_reg)
      12'h300: csr_rd_bus = fMstatus;
      12'h305: csr_rd_bus = fMtvec;
      12'h341: csr_rd_bus = fMepc;
      12'h342: csr_rd_bus = fMcause;
      default: csr_rd_bus = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fileRst) begin
      fMstatus <= 32'h1800;
      fMtvec   <= '0;
      fMepc    <= '0;
      fMcause  <= '0;
    end else if (csr_wr_en) begin
      case (csr_wr_reg)
        12'h300: fMstatus <= csr_wr_set ? (fMstatus | csr_wr_bus) : csr_wr_bus;
        12'h305: fMtvec   <= csr_wr_set ? (fMtvec   | csr_wr_bus) : csr_wr_bus;
        12'h341: fMepc    <= csr_wr_set ? (fMepc    | csr_wr_bus) : csr_wr_bus;
        12'h342: fMcause  <= csr_wr_set ? (fMcause  | csr_wr_bus) : csr_wr_bus;
        default: ;
      endcase
    end
  end

  // Reference model: architectural CSR contents plus the cycles each instruction should produce
  typedef struct packed {
    logic        wrEn;
    logic        wrSet;
    logic [11:0] wrReg;
    logic [31:0] wrBus;
    logic        doneV;
    logic [31:0] doneData;
    logic        redirV;
    logic [31:0] redirPc;
  } cycleT;

  cycleT       expQ[$];
  logic [31:0] mCsr [4];

  function automatic int csrIdx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] mRead(input logic [11:0] a);
    int k = csrIdx(a);
    return (k < 0) ? 32'h0 : mCsr[k];
  endfunction

  function automatic void mWrite(input logic [11:0] a, input logic [31:0] v, input logic setMode);
    int k = csrIdx(a);
    if (k >= 0) mCsr[k] = setMode ? (mCsr[k] | v) : v;
  endfunction

  function automatic void modelRun(input logic [2:0] op, input logic [31:0] pc,
                                   input logic [11:0] csr, input logic [31:0] src);
    cycleT c;
    logic [31:0] old;
    old = mRead(csr);
    c = '0;
    case (op)
      3'd1: begin
        c.wrEn = 1'b1; c.wrReg = csr; c.wrBus = src;
        c.doneV = 1'b1; c.doneData = old;
        expQ.push_back(c);
        mWrite(csr, src, 1'b0);
      end
      3'd2: begin
        if (src != 0) begin
          c.wrEn = 1'b1; c.wrSet = 1'b1; c.wrReg = csr; c.wrBus = src;
          mWrite(csr, src, 1'b1);
        end
        c.doneV = 1'b1; c.doneData = old;
        expQ.push_back(c);
      end
      3'd3: begin
        c.wrEn = 1'b1; c.wrReg = 12'h341; c.wrBus = pc;
        expQ.push_back(c);
        mWrite(12'h341, pc, 1'b0);
        c = '0;
        c.wrEn = 1'b1; c.wrReg = 12'h342; c.wrBus = 32'd11;
        expQ.push_back(c);
        mWrite(12'h342, 32'd11, 1'b0);
        c = '0;
        c.doneV = 1'b1; c.redirV = 1'b1; c.redirPc = mRead(12'h305) & ~32'h3;
        expQ.push_back(c);
      end
      3'd4: begin
        c.doneV = 1'b1; c.redirV = 1'b1; c.redirPc = mRead(12'h341);
        expQ.push_back(c);
      end
      default: begin
        c.doneV = 1'b1;
        expQ.push_back(c);
      end
    endcase
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
  endtask

  task automatic checkOutput(input cycleT e, input logic [11:0] csr, input string tag);
    checkValue({tag, ".ctl"},
               {in_ready, busy, csr_wr_en, csr_wr_set, done_valid, redirect_valid, csr_rd_reg},
               {1'b0, 1'b1, e.wrEn, e.wrSet, e.doneV, e.redirV, csr});
    checkValue({tag, ".wr"}, {csr_wr_reg, csr_wr_bus}, {e.wrReg, e.wrBus});
    if (e.doneV)  checkValue({tag, ".rdata"}, done_rdata, e.doneData);
    if (e.redirV) checkValue({tag, ".rpc"}, redirect_pc, e.redirPc);
  endtask

  task automatic checkFile(input string tag);
    checkValue({tag, ".file"}, {fMstatus, fMtvec}, {mCsr[0], mCsr[1]});
    checkValue({tag, ".file2"}, {fMepc, fMcause}, {mCsr[2], mCsr[3]});
  endtask

  // Entered 1ns after a rising edge with the sequencer expected idle; returns the same way
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] pc,
                               input logic [11:0] csr, input logic [31:0] src,
                               input string tag, output logic [31:0] gotRdata,
                               output logic gotRedir, output logic [31:0] gotRpc,
                               output int gotCycles);
    cycleT e;
    int idx;
    modelRun(op, pc, csr, src);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_csr = csr; in_src = src;
    @(negedge clk);
    checkValue({tag, ".accept"},
               {in_ready, busy, csr_wr_en, done_valid, redirect_valid, csr_rd_reg},
               {1'b1, 4'b0, csr});
    @(posedge clk); #1;
    in_valid = 1'b0;
    gotRdata = '0; gotRedir = 1'b0; gotRpc = '0; gotCycles = 0; idx = 0;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      idx++;
      @(negedge clk);
      checkOutput(e, csr, $sformatf("%s.c%0d", tag, idx));
      if (done_valid) begin
        gotRdata  = done_rdata;
        gotCycles = idx;
      end
      if (redirect_valid) begin
        gotRedir = 1'b1;
        gotRpc   = redirect_pc;
      end
      @(posedge clk); #1;
    end
    checkFile(tag);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc;
    logic [11:0] csr;
    logic [31:0] src;
    logic [31:0] expRdata;
    logic        expRedir;
    logic [31:0] expRpc;
    int          expCycles;
  } vecT;

  vecT tbl[13];

  initial begin
    logic [31:0] rdata, rpc, firstOld;
    logic        redir;
    int          cyc;
    string       tag;

    tbl[0]  = '{3'd1, 32'h0,         12'h305, 32'h8000_0100, 32'h0,         1'b0, 32'h0,         1};
    tbl[1]  = '{3'd2, 32'h0,         12'h300, 32'h8,         32'h1800,      1'b0, 32'h0,         1};
    tbl[2]  = '{3'd2, 32'h0,         12'h300, 32'h0,         32'h1808,      1'b0, 32'h0,         1};
    tbl[3]  = '{3'd3, 32'h8000_0040, 12'h000, 32'h0,         32'h0,         1'b1, 32'h8000_0100, 3};
    tbl[4]  = '{3'd1, 32'h0,         12'h341, 32'h8000_0044, 32'h8000_0040, 1'b0, 32'h0,         1};
    tbl[5]  = '{3'd4, 32'h0,         12'h000, 32'h0,         32'h0,         1'b1, 32'h8000_0044, 1};
    tbl[6]  = '{3'd0, 32'h0,         12'h305, 32'hFFFF,      32'h0,         1'b0, 32'h0,         1};
    tbl[7]  = '{3'd7, 32'h0,         12'h300, 32'h5,         32'h0,         1'b0, 32'h0,         1};
    tbl[8]  = '{3'd1, 32'h0,         12'h342, 32'h5,         32'd11,        1'b0, 32'h0,         1};
    tbl[9]  = '{3'd1, 32'h0,         12'h7C0, 32'h123,       32'h0,         1'b0, 32'h0,         1};
    tbl[10] = '{3'd1, 32'h0,         12'h305, 32'h8000_0103, 32'h8000_0100, 1'b0, 32'h0,         1};
    tbl[11] = '{3'd3, 32'h0000_1000, 12'h305, 32'h0,         32'h0,         1'b1, 32'h8000_0100, 3};
    tbl[12] = '{3'd5, 32'h0,         12'h300, 32'h7,         32'h0,         1'b0, 32'h0,         1};

    mCsr[0] = 32'h1800; mCsr[1] = '0; mCsr[2] = '0; mCsr[3] = '0;
    rst = 1'b1; fileRst = 1'b1;
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_csr = 12'hABC; in_src = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset.ready", in_ready, 0);
    checkValue("reset.outs",
               {busy, csr_wr_en, csr_wr_set, csr_wr_reg, csr_wr_bus, done_valid,
                done_rdata, redirect_valid},
               0);
    checkValue("reset.rdreg", csr_rd_reg, 12'hABC);
    @(posedge clk); #1;
    rst = 1'b0; fileRst = 1'b0;
    @(negedge clk);
    checkValue("reset.readyAfter", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(tbl[i].op, tbl[i].pc, tbl[i].csr, tbl[i].src, tag, rdata, redir, rpc, cyc);
      checkValue({tag, ".rdata"}, rdata, tbl[i].expRdata);
      checkValue({tag, ".redir"}, redir, tbl[i].expRedir);
      if (tbl[i].expRedir) checkValue({tag, ".rpc"}, rpc, tbl[i].expRpc);
      checkValue({tag, ".cycles"}, cyc, tbl[i].expCycles);
    end

    // Reset arriving in the mcause cycle of an ECALL aborts the rest of the trap
    in_valid = 1'b1; in_op = 3'd3; in_pc = 32'hAAAA_0000; in_csr = '0; in_src = '0;
    @(negedge clk);
    checkValue("rstEcall.accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkValue("rstEcall.epc", {csr_wr_en, csr_wr_reg, csr_wr_bus}, {1'b1, 12'h341, 32'hAAAA_0000});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkValue("rstEcall.quiet",
               {in_ready, busy, csr_wr_en, done_valid, redirect_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkValue("rstEcall.after", {in_ready, busy, csr_wr_en, done_valid, redirect_valid}, 5'b10000);
    mCsr[2] = 32'hAAAA_0000;
    checkFile("rstEcall");
    @(posedge clk); #1;

    // Back-to-back CSRRW with in_valid held: accepts two cycles apart, second sees first's write
    firstOld = mCsr[1];
    in_valid = 1'b1; in_op = 3'd1; in_csr = 12'h305; in_src = 32'h1111_0000;
    @(negedge clk);
    checkValue("b2b.accept0", in_ready, 1);
    @(posedge clk); #1;
    in_src = 32'h2222_0000;
    @(negedge clk);
    checkValue("b2b.stall", {in_ready, csr_wr_en, csr_wr_bus}, {1'b0, 1'b1, 32'h1111_0000});
    checkValue("b2b.rdata0", {done_valid, done_rdata}, {1'b1, firstOld});
    @(posedge clk); #1;
    @(negedge clk);
    checkValue("b2b.accept1", {in_ready, csr_wr_en, done_valid}, 3'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkValue("b2b.rdata1", {done_valid, done_rdata, csr_wr_bus}, {1'b1, 32'h1111_0000, 32'h2222_0000});
    @(posedge clk); #1;
    mCsr[1] = 32'h2222_0000;
    checkFile("b2b");

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [11:0] csr;
      logic [31:0] src;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: csr = 12'h300;
        1: csr = 12'h305;
        2: csr = 12'h341;
        3: csr = 12'h342;
        default: csr = 12'($urandom);
      endcase
      src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      applyStimulus(op, $urandom, csr, src, $sformatf("rnd%0d", i), rdata, redir, rpc, cyc);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
